// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - cause codes, register offsets and reset constants for irq_clint
package irq_pkg;

  localparam int CAUSE_MTIMER   = 7;
  localparam int CAUSE_EXT_BASE = 16;

  localparam logic [7:0] OFF_MTIME_LO    = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI    = 8'h04;
  localparam logic [7:0] OFF_MTIMECMP_LO = 8'h08;
  localparam logic [7:0] OFF_MTIMECMP_HI = 8'h0C;
  localparam logic [7:0] OFF_PENDING     = 8'h10;
  localparam logic [7:0] OFF_ENABLE      = 8'h14;
  localparam logic [7:0] OFF_CLAIM       = 8'h18;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/irq_mtimer.sv
// rtl/irq_mtimer.sv - prescaled 64-bit machine timer with compare and its bus-written registers
module irq_mtimer #(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  bus_word,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        timer_irq
);
  import irq_pkg::*;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RESET;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      // a software write to either mtime half suppresses that cycle's increment
      if (bus_we && bus_word == OFF_MTIME_LO[7:2])
        mtime[31:0] <= bus_wdata;
      else if (bus_we && bus_word == OFF_MTIME_HI[7:2])
        mtime[63:32] <= bus_wdata;
      else if (tick)
        mtime <= mtime + 64'd1;
      if (bus_we && bus_word == OFF_MTIMECMP_LO[7:2])
        mtimecmp[31:0] <= bus_wdata;
      if (bus_we && bus_word == OFF_MTIMECMP_HI[7:2])
        mtimecmp[63:32] <= bus_wdata;
    end
  end

  assign timer_irq = (mtime >= mtimecmp);

endmodule

// File: rtl/irq_clint.sv
// rtl/irq_clint.sv - machine interrupt source block: timer, ext edge capture, pending/enable, priority
module irq_clint #(
  parameter int NUM_EXT  = 2,
  parameter int PRESCALE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic [7:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  input  logic               bus_we,
  input  logic               bus_re,
  output logic [31:0]        bus_rdata,
  input  logic               irq_ack,
  output logic               timer_irq,
  output logic [31:0]        interrupt_pend,
  output logic [31:0]        interrupt_cause
);
  import irq_pkg::*;

  logic [5:0]         bus_word;
  logic               addr_unused;
  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic [NUM_EXT-1:0] ext_d;
  logic [NUM_EXT-1:0] ext_pend;
  logic [NUM_EXT-1:0] ext_rise;
  logic [NUM_EXT-1:0] ext_clr;
  logic [31:0]        enable;
  logic [31:0]        enable_mask;
  logic [31:0]        pending;
  logic [31:0]        active;
  logic [31:0]        sel_cause;

  assign bus_word    = bus_addr[7:2];
  assign addr_unused = ^bus_addr[1:0];
  assign ext_rise    = ext_irq & ~ext_d;

  irq_mtimer #(.PRESCALE(PRESCALE)) u_mtimer (
    .clk       (clk),
    .reset     (reset),
    .bus_word  (bus_word),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .mtime     (mtime),
    .mtimecmp  (mtimecmp),
    .timer_irq (timer_irq)
  );

  always_comb begin
    pending = '0;
    pending[CAUSE_MTIMER] = timer_irq;
    pending[CAUSE_EXT_BASE +: NUM_EXT] = ext_pend;
    enable_mask = '0;
    enable_mask[CAUSE_MTIMER] = 1'b1;
    enable_mask[CAUSE_EXT_BASE +: NUM_EXT] = '1;
    active = pending & enable;
  end

  always_comb begin
    ext_clr = '0;
    for (int i = 0; i < NUM_EXT; i++)
      ext_clr[i] = (bus_we && bus_word == OFF_PENDING[7:2] && bus_wdata[CAUSE_EXT_BASE + i]) ||
                   (irq_ack && interrupt_pend == 32'(CAUSE_EXT_BASE + i));
  end

  // lower ext index overrides, so the loop runs from the weakest source upward
  always_comb begin
    sel_cause = '0;
    if (active[CAUSE_MTIMER])
      sel_cause = 32'(CAUSE_MTIMER);
    for (int i = NUM_EXT - 1; i >= 0; i--)
      if (active[CAUSE_EXT_BASE + i])
        sel_cause = 32'(CAUSE_EXT_BASE + i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_d           <= '0;
      ext_pend        <= '0;
      enable          <= '0;
      interrupt_pend  <= '0;
      interrupt_cause <= '0;
    end else begin
      ext_d           <= ext_irq;
      ext_pend        <= ext_rise | (ext_pend & ~ext_clr);
      interrupt_cause <= active;
      interrupt_pend  <= sel_cause;
      if (bus_we && bus_word == OFF_ENABLE[7:2])
        enable <= bus_wdata & enable_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_rdata <= '0;
    end else if (bus_re) begin
      case (bus_word)
        OFF_MTIME_LO[7:2]:    bus_rdata <= mtime[31:0];
        OFF_MTIME_HI[7:2]:    bus_rdata <= mtime[63:32];
        OFF_MTIMECMP_LO[7:2]: bus_rdata <= mtimecmp[31:0];
        OFF_MTIMECMP_HI[7:2]: bus_rdata <= mtimecmp[63:32];
        OFF_PENDING[7:2]:     bus_rdata <= pending;
        OFF_ENABLE[7:2]:      bus_rdata <= enable;
        OFF_CLAIM[7:2]:       bus_rdata <= interrupt_pend;
        default:              bus_rdata <= '0;
      endcase
    end
  end

endmodule
